// File: rtl/ibex_rf_wb_pkg.sv
// Shared types and helpers for the register-file writeback sequencer.
package ibex_rf_wb_pkg;

  localparam int unsigned RfAddrW = 5;

  typedef struct packed {
    logic [RfAddrW-1:0] waddr;
    logic [31:0]        wdata;
  } wb_req_t;

  // In RV32E only the low four address bits select a register.
  function automatic logic is_x0(input logic [RfAddrW-1:0] addr, input logic rv32e);
    return rv32e ? (addr[3:0] == 4'd0) : (addr == 5'd0);
  endfunction

endpackage

// File: rtl/ibex_rf_wb_fifo.sv
// Circular-buffer FIFO for LSU writebacks with synchronous flush.
module ibex_rf_wb_fifo #(
  parameter int unsigned Depth = 2,
  parameter int unsigned Width = 37
) (
  input  logic             clk_int,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign rdata_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop_i)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      if (push_i && !pop_i)      count_q <= count_q + CntW'(1);
      else if (!push_i && pop_i) count_q <= count_q - CntW'(1);
    end
  end

  // Storage is only ever read through a valid head, so it needs no reset.
  always_ff @(posedge clk_int) begin
    if (push_i && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/ibex_rf_wb_sequencer.sv
// Merges EX and buffered LSU writebacks onto the single RF write port.
// Optional macro RF_WB_STALL_CNT_EN adds a saturating EX stall-cycle counter.
module ibex_rf_wb_sequencer
  import ibex_rf_wb_pkg::*;
#(
  parameter int unsigned          DataWidth    = 32,
  parameter bit                   RV32E        = 1'b0,
  parameter int unsigned          LsuFifoDepth = 2,
  parameter logic [DataWidth-1:0] WordZeroVal  = '0
) (
  input  logic                 clk_int,
  input  logic                 rst_ni,
  input  logic                 flush_i,
  input  logic                 ex_valid_i,
  input  logic [4:0]           ex_waddr_i,
  input  logic [DataWidth-1:0] ex_wdata_i,
  output logic                 ex_ready_o,
  input  logic                 lsu_valid_i,
  input  logic [4:0]           lsu_waddr_i,
  input  logic [DataWidth-1:0] lsu_wdata_i,
  output logic                 lsu_ready_o,
  output logic                 rf_we_o,
  output logic [4:0]           rf_waddr_o,
  output logic [DataWidth-1:0] rf_wdata_o,
  output logic                 pend_valid_o,
  output logic [4:0]           pend_waddr_o,
  output logic [DataWidth-1:0] pend_wdata_o,
`ifdef RF_WB_STALL_CNT_EN
  output logic [15:0]          ex_stall_cnt_o,
`endif
  output logic                 busy_o
);

  localparam int unsigned        EntryW   = RfAddrW + DataWidth;
  localparam logic [RfAddrW-1:0] AddrMask = RV32E ? 5'h0F : 5'h1F;

  logic                 fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [EntryW-1:0]    fifo_head;
  logic [RfAddrW-1:0]   head_waddr, ex_waddr;
  logic [DataWidth-1:0] head_wdata;
  logic                 head_x0, ex_x0, addr_hit, pick_head, issue_ex;

  logic                 pend_valid_q;
  logic [RfAddrW-1:0]   pend_waddr_q;
  logic [DataWidth-1:0] pend_wdata_q;

  // A pop in the same cycle frees a slot, so a full FIFO can still accept.
  assign lsu_ready_o = ~fifo_full | fifo_pop;
  assign fifo_push   = lsu_valid_i & lsu_ready_o;

  ibex_rf_wb_fifo #(
    .Depth (LsuFifoDepth),
    .Width (EntryW)
  ) u_lsu_fifo (
    .clk_int (clk_int),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (fifo_push),
    .wdata_i ({lsu_waddr_i, lsu_wdata_i}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign head_waddr = fifo_head[EntryW-1 -: RfAddrW] & AddrMask;
  assign head_wdata = fifo_head[DataWidth-1:0];
  assign ex_waddr   = ex_waddr_i & AddrMask;
  assign head_x0    = is_x0(head_waddr, RV32E);
  assign ex_x0      = is_x0(ex_waddr, RV32E);

  // Same destination: the older LSU write must land before the EX write.
  assign addr_hit   = (head_waddr == ex_waddr) & ~head_x0 & ~ex_x0;
  assign pick_head  = ~fifo_empty & (fifo_full | addr_hit | ~ex_valid_i);
  assign issue_ex   = ex_valid_i & ~pick_head;
  assign fifo_pop   = pick_head;
  assign ex_ready_o = ~pick_head;

  always_comb begin
    rf_we_o    = 1'b0;
    rf_waddr_o = '0;
    rf_wdata_o = WordZeroVal;
    if (pick_head) begin
      rf_we_o    = ~head_x0;
      rf_waddr_o = head_waddr;
      rf_wdata_o = head_wdata;
    end else if (issue_ex) begin
      rf_we_o    = ~ex_x0;
      rf_waddr_o = ex_waddr;
      rf_wdata_o = ex_wdata_i;
    end
  end

  // Mirrors the write the latch RF is committing this cycle, for forwarding.
  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      pend_valid_q <= 1'b0;
      pend_waddr_q <= '0;
      pend_wdata_q <= WordZeroVal;
    end else begin
      pend_valid_q <= rf_we_o;
      if (rf_we_o) begin
        pend_waddr_q <= rf_waddr_o;
        pend_wdata_q <= rf_wdata_o;
      end
    end
  end

  assign pend_valid_o = pend_valid_q;
  assign pend_waddr_o = pend_waddr_q;
  assign pend_wdata_o = pend_wdata_q;
  assign busy_o       = ~fifo_empty | pend_valid_q;

`ifdef RF_WB_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk_int or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (ex_valid_i && !ex_ready_o && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign ex_stall_cnt_o = stall_cnt_q;
`endif

endmodule

// File: tb/tb_ibex_rf_wb_sequencer.sv
// Scoreboard bench for ibex_rf_wb_sequencer; covers RF_WB_STALL_CNT_EN when defined.
module tb_ibex_rf_wb_sequencer;

  logic        clk_int = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        ex_valid_i, lsu_valid_i;
  logic [4:0]  ex_waddr_i, lsu_waddr_i;
  logic [31:0] ex_wdata_i, lsu_wdata_i;
  logic        ex_ready_o, lsu_ready_o, rf_we_o, pend_valid_o, busy_o;
  logic [4:0]  rf_waddr_o, pend_waddr_o;
  logic [31:0] rf_wdata_o, pend_wdata_o;
`ifdef RF_WB_STALL_CNT_EN
  logic [15:0] ex_stall_cnt_o;
`endif

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t exp_q[$];
  wr_t pend_q[$];
  int  total = 0;
  int  bad   = 0;
  bit  sb_en = 1'b1;

  always #5 clk_int = ~clk_int;

  ibex_rf_wb_sequencer dut (
    .clk_int        (clk_int),
    .rst_ni         (rst_ni),
    .flush_i        (flush_i),
    .ex_valid_i     (ex_valid_i),
    .ex_waddr_i     (ex_waddr_i),
    .ex_wdata_i     (ex_wdata_i),
    .ex_ready_o     (ex_ready_o),
    .lsu_valid_i    (lsu_valid_i),
    .lsu_waddr_i    (lsu_waddr_i),
    .lsu_wdata_i    (lsu_wdata_i),
    .lsu_ready_o    (lsu_ready_o),
    .rf_we_o        (rf_we_o),
    .rf_waddr_o     (rf_waddr_o),
    .rf_wdata_o     (rf_wdata_o),
    .pend_valid_o   (pend_valid_o),
    .pend_waddr_o   (pend_waddr_o),
    .pend_wdata_o   (pend_wdata_o),
`ifdef RF_WB_STALL_CNT_EN
    .ex_stall_cnt_o (ex_stall_cnt_o),
`endif
    .busy_o         (busy_o)
  );

  task automatic chk(input string name, input logic [36:0] act, input logic [36:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, req);
    end
  endtask

  task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
    pend_q.push_back({a, d});
  endtask

  task automatic drive(input logic ev, input logic [4:0] ea, input logic [31:0] ed,
                       input logic lv, input logic [4:0] la, input logic [31:0] ld,
                       input logic fl);
    ex_valid_i  = ev;
    ex_waddr_i  = ea;
    ex_wdata_i  = ed;
    lsu_valid_i = lv;
    lsu_waddr_i = la;
    lsu_wdata_i = ld;
    flush_i     = fl;
  endtask

  task automatic next_cycle();
    @(posedge clk_int);
    #1;
  endtask

  // Monitor: every RF write and every pending-stage value must match the queue head.
  always @(negedge clk_int) begin
    if (rst_ni && sb_en) begin
      if (rf_we_o) begin
        if (exp_q.size() == 0) chk("rf_write_unexpected", {rf_waddr_o, rf_wdata_o}, '0);
        else chk("rf_write", {rf_waddr_o, rf_wdata_o}, exp_q.pop_front());
      end
      if (pend_valid_o) begin
        if (pend_q.size() == 0) chk("pend_unexpected", {pend_waddr_o, pend_wdata_o}, '0);
        else chk("pend", {pend_waddr_o, pend_wdata_o}, pend_q.pop_front());
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_int);
    chk("rst_rf_we", rf_we_o, 0);
    chk("rst_lsu_ready", lsu_ready_o, 1);
    chk("rst_ex_ready", ex_ready_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_pend_valid", pend_valid_o, 0);
    chk("rst_pend_data", {pend_waddr_o, pend_wdata_o}, '0);
    next_cycle();
    rst_ni = 1'b1;

    // 1: plain EX write, then pending stage
    drive(1, 5'd5, 32'hDEAD_BEEF, 0, 0, 0, 0);
    expect_wr(5'd5, 32'hDEAD_BEEF);
    @(negedge clk_int);
    chk("t1_rf_we", rf_we_o, 1);
    chk("t1_ex_ready", ex_ready_o, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_int);
    chk("t1_pend_valid", pend_valid_o, 1);
    chk("t1_pend_wdata", pend_wdata_o, 32'hDEAD_BEEF);
    chk("t1_idle_addr", rf_waddr_o, 0);
    chk("t1_idle_data", rf_wdata_o, 0);
    next_cycle();

    // 2: fill FIFO while EX keeps writing x7
    drive(1, 5'd7, 32'h77, 1, 5'd3, 32'd1, 0);
    expect_wr(5'd7, 32'h77);
    @(negedge clk_int);
    chk("t2_c0_lsu_ready", lsu_ready_o, 1);
    next_cycle();
    drive(1, 5'd7, 32'h77, 1, 5'd4, 32'd2, 0);
    expect_wr(5'd7, 32'h77);
    @(negedge clk_int);
    chk("t2_c1_ex_ready", ex_ready_o, 1);
    next_cycle();
    drive(1, 5'd7, 32'h77, 0, 0, 0, 0);
    expect_wr(5'd3, 32'd1);
    @(negedge clk_int);
    chk("t2_full_ex_ready", ex_ready_o, 0);
    chk("t2_full_lsu_ready", lsu_ready_o, 1);
    chk("t2_busy", busy_o, 1);
    next_cycle();
    expect_wr(5'd7, 32'h77);
    @(negedge clk_int);
    chk("t2_c3_ex_ready", ex_ready_o, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    expect_wr(5'd4, 32'd2);
    @(negedge clk_int);
    chk("t2_c4_ex_ready", ex_ready_o, 0);
    chk("t2_c4_rf_we", rf_we_o, 1);
    next_cycle();
    next_cycle();

    // 3: address conflict with FIFO head
    drive(0, 0, 0, 1, 5'd9, 32'h99, 0);
    @(negedge clk_int);
    chk("t3_no_bypass", rf_we_o, 0);
    next_cycle();
    drive(1, 5'd9, 32'hE9, 0, 0, 0, 0);
    expect_wr(5'd9, 32'h99);
    @(negedge clk_int);
    chk("t3_hit_ex_ready", ex_ready_o, 0);
    next_cycle();
    expect_wr(5'd9, 32'hE9);
    @(negedge clk_int);
    chk("t3_ex_ready", ex_ready_o, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_int);
    chk("t3_pend_wdata", pend_wdata_o, 32'hE9);
    next_cycle();

    // 4: write to x0
    drive(1, 5'd0, 32'h1234, 0, 0, 0, 0);
    @(negedge clk_int);
    chk("t4_ex_ready", ex_ready_o, 1);
    chk("t4_rf_we", rf_we_o, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_int);
    chk("t4_pend_valid", pend_valid_o, 0);
    next_cycle();

    // 5: flush with two queued entries and a same-cycle push
    drive(1, 5'd11, 32'hB, 1, 5'd10, 32'hA, 0);
    expect_wr(5'd11, 32'hB);
    next_cycle();
    drive(1, 5'd11, 32'hB, 1, 5'd12, 32'hC, 0);
    expect_wr(5'd11, 32'hB);
    next_cycle();
    drive(0, 0, 0, 1, 5'd13, 32'hD, 1);
    expect_wr(5'd10, 32'hA);
    @(negedge clk_int);
    chk("t5_flush_pend_valid", pend_valid_o, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    @(negedge clk_int);
    chk("t5_after_rf_we", rf_we_o, 0);
    chk("t5_after_pend_valid", pend_valid_o, 1);
    chk("t5_after_busy", busy_o, 1);
    chk("t5_after_ex_ready", ex_ready_o, 1);
    next_cycle();
    @(negedge clk_int);
    chk("t5_drained_busy", busy_o, 0);
    chk("t5_drained_pend", pend_valid_o, 0);
    next_cycle();

    // Reset mid-operation drops the queued entry
    drive(0, 0, 0, 1, 5'd14, 32'hE, 0);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_ni = 1'b0;
    @(negedge clk_int);
    chk("rst_mid_busy", busy_o, 0);
    chk("rst_mid_lsu_ready", lsu_ready_o, 1);
    next_cycle();
    rst_ni = 1'b1;
    @(negedge clk_int);
    chk("rst_lost_rf_we", rf_we_o, 0);
    chk("rst_lost_busy", busy_o, 0);
    next_cycle();

`ifdef RF_WB_STALL_CNT_EN
    // 6: stall counter
    chk("t6_cnt_zero", ex_stall_cnt_o, 0);
    drive(0, 0, 0, 1, 5'd20, 32'h201, 0);
    next_cycle();
    drive(1, 5'd20, 32'hE20, 1, 5'd20, 32'h202, 0);
    expect_wr(5'd20, 32'h201);
    next_cycle();
    drive(1, 5'd20, 32'hE20, 1, 5'd20, 32'h203, 0);
    expect_wr(5'd20, 32'h202);
    next_cycle();
    drive(1, 5'd20, 32'hE20, 0, 0, 0, 0);
    expect_wr(5'd20, 32'h203);
    next_cycle();
    expect_wr(5'd20, 32'hE20);
    @(negedge clk_int);
    chk("t6_cnt_3", ex_stall_cnt_o, 3);
    chk("t6_ex_ready", ex_ready_o, 1);
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    sb_en = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      drive(1, 5'd20, 32'hE20, 1, 5'd20, i, 0);
      next_cycle();
    end
    drive(0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk_int);
    chk("t6_cnt_sat", ex_stall_cnt_o, 16'hFFFF);
    exp_q.delete();
    pend_q.delete();
    sb_en = 1'b1;
`endif

    next_cycle();
    chk("sb_rf_drained", exp_q.size(), 0);
    chk("sb_pend_drained", pend_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
